mem_arbiter: RTL and testbench

- Arbitrates a single shared memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) of the multi-cycle npc core.
- Sits between the IFU/LSU and the memory/bus bridge.
- Accepts one request at a time from the winning requester, holds it on the memory port until accepted, then routes the response back to the owner.
- One transaction in flight, no reordering.

---
 rtl/npc_pkg.sv | 7 +
 rtl/arb_pick2.sv | 9 +
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared FSM/owner encodings and default widths for the npc memory path.
package npc_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;
endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: two-way combinational picker; req[0]=IFU, req[1]=LSU, last_loser=1 means LSU lost the last tie.
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       prio_lsu,
    input  logic       last_loser,
    output logic [1:0] grant
);
    assign grant = (&req) ? ((prio_lsu || last_loser) ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU, one transaction in flight.
module mem_arbiter
    import npc_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LSU_PRIO = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);
    state_t              state_q, state_d;
    owner_t              owner_q, owner_d, last_loser_q, last_loser_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    logic [1:0]          grant;
    logic                idle, ifu_hs, lsu_hs, resp_fire;

    arb_pick2 u_pick (
        .req       ({lsu_req_valid, ifu_req_valid}),
        .prio_lsu  (LSU_PRIO != 0),
        .last_loser(last_loser_q == OWN_LSU),
        .grant     (grant)
    );

    assign idle          = !rst && state_q == IDLE;
    assign ifu_hs        = idle && grant[0];
    assign lsu_hs        = idle && grant[1];
    assign ifu_req_ready = ifu_hs;
    assign lsu_req_ready = lsu_hs;
    assign mem_req_valid = !rst && state_q == REQ;
    // Zero-wait memory may answer in the same cycle it accepts the request.
    assign resp_fire     = !rst && mem_resp_valid &&
                           (state_q == WAIT || (state_q == REQ && mem_req_ready));
    assign ifu_resp_valid = resp_fire && owner_q == OWN_IFU;
    assign lsu_resp_valid = resp_fire && owner_q == OWN_LSU;
    assign ifu_resp_data  = mem_resp_data;
    assign lsu_resp_data  = mem_resp_data;
    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_loser_d = last_loser_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        if (ifu_hs || lsu_hs) begin
            state_d = REQ;
            owner_d = lsu_hs ? OWN_LSU : OWN_IFU;
            addr_d  = lsu_hs ? lsu_addr : ifu_addr;
            wen_d   = lsu_hs && lsu_wen;
            wdata_d = lsu_hs ? lsu_wdata : '0;
            wmask_d = lsu_hs ? lsu_wmask : '0;
            if (ifu_req_valid && lsu_req_valid)
                last_loser_d = lsu_hs ? OWN_IFU : OWN_LSU;
        end else if (state_q == REQ && mem_req_ready) begin
            state_d = mem_resp_valid ? IDLE : WAIT;
        end else if (state_q == WAIT && mem_resp_valid) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IFU;
            last_loser_q <= OWN_IFU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_loser_q <= last_loser_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level model checks for LSU-priority (dut 0) and round-robin (dut 1) arbiters.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_v[2], lsu_v[2], lsu_w[2], mem_rdy[2], mem_rv[2];
    logic [31:0] ifu_a[2], lsu_a[2], lsu_wd[2], mem_rd[2];
    logic [3:0]  lsu_m[2];
    logic        ifu_rdy[2], lsu_rdy[2], ifu_rv[2], lsu_rv[2], mem_v[2], mem_w[2];
    logic [31:0] ifu_rd[2], lsu_rd[2], mem_a[2], mem_wd[2];
    logic [3:0]  mem_m[2];
    int          checks = 0, errors = 0;
    bit          p_i[2], p_l[2], p_lw[2], m_loser[2];
    logic [31:0] p_ia[2], p_la[2], p_lwd[2];
    logic [3:0]  p_lm[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(g == 0 ? 1 : 0)) dut (
            .clk(clk), .rst(rst),
            .ifu_req_valid(ifu_v[g]), .ifu_req_ready(ifu_rdy[g]), .ifu_addr(ifu_a[g]),
            .ifu_resp_valid(ifu_rv[g]), .ifu_resp_data(ifu_rd[g]),
            .lsu_req_valid(lsu_v[g]), .lsu_req_ready(lsu_rdy[g]), .lsu_addr(lsu_a[g]),
            .lsu_wen(lsu_w[g]), .lsu_wdata(lsu_wd[g]), .lsu_wmask(lsu_m[g]),
            .lsu_resp_valid(lsu_rv[g]), .lsu_resp_data(lsu_rd[g]),
            .mem_req_valid(mem_v[g]), .mem_req_ready(mem_rdy[g]), .mem_addr(mem_a[g]),
            .mem_wen(mem_w[g]), .mem_wdata(mem_wd[g]), .mem_wmask(mem_m[g]),
            .mem_resp_valid(mem_rv[g]), .mem_resp_data(mem_rd[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input int d);
        chk("rdy_i_0", ifu_rdy[d], 0); chk("rdy_l_0", lsu_rdy[d], 0);
        chk("rv_i_0", ifu_rv[d], 0);   chk("rv_l_0", lsu_rv[d], 0);
        chk("mv_0", mem_v[d], 0);      chk("ma_0", mem_a[d], 0);
        chk("mw_0", mem_w[d], 0);      chk("mwd_0", mem_wd[d], 0);
        chk("mm_0", mem_m[d], 0);
    endtask

    // One arbitration round: add new requests, predict the winner, then play memory with stall/latency.
    task automatic txn(input int d, input bit ni, input logic [31:0] ia, input bit nl,
                       input logic [31:0] la, input bit lw, input logic [31:0] lwd,
                       input logic [3:0] lm, input int stall, input int lat, input logic [31:0] rd);
        bit pick_lsu, rv;
        logic [31:0] ea, ewd;
        logic ew;
        logic [3:0] em;
        if (ni && !p_i[d]) begin p_i[d] = 1; p_ia[d] = ia; end
        if (nl && !p_l[d]) begin p_l[d] = 1; p_la[d] = la; p_lw[d] = lw; p_lwd[d] = lwd; p_lm[d] = lm; end
        if (!p_i[d] && !p_l[d]) return;
        ifu_v[d] = p_i[d]; ifu_a[d] = p_ia[d];
        lsu_v[d] = p_l[d]; lsu_a[d] = p_la[d]; lsu_w[d] = p_lw[d]; lsu_wd[d] = p_lwd[d]; lsu_m[d] = p_lm[d];
        if (p_i[d] && p_l[d]) begin
            pick_lsu = (d == 0) ? 1'b1 : m_loser[d];
            m_loser[d] = !pick_lsu;
        end else pick_lsu = p_l[d];
        #1;
        chk("ifu_ready", ifu_rdy[d], !pick_lsu);
        chk("lsu_ready", lsu_rdy[d], pick_lsu);
        if (pick_lsu) begin ea = p_la[d]; ew = p_lw[d]; ewd = p_lwd[d]; em = p_lm[d]; p_l[d] = 0; end
        else begin ea = p_ia[d]; ew = 0; ewd = 0; em = 0; p_i[d] = 0; end
        @(posedge clk); #1;
        ifu_v[d] = p_i[d]; lsu_v[d] = p_l[d];
        for (int s = 0; s <= stall; s++) begin
            rv = (s == stall) && (lat == 0);
            mem_rdy[d] = (s == stall); mem_rv[d] = rv; mem_rd[d] = rd;
            #1;
            chk("req_valid", mem_v[d], 1);
            chk("mem_addr", mem_a[d], ea);
            chk("mem_wen", mem_w[d], ew);
            chk("mem_wmask", mem_m[d], em);
            if (pick_lsu) chk("mem_wdata", mem_wd[d], ewd);
            chk("ifu_ready_busy", ifu_rdy[d], 0);
            chk("lsu_ready_busy", lsu_rdy[d], 0);
            chk("ifu_resp_req", ifu_rv[d], rv && !pick_lsu);
            chk("lsu_resp_req", lsu_rv[d], rv && pick_lsu);
            if (rv) chk("resp_data0", pick_lsu ? lsu_rd[d] : ifu_rd[d], rd);
            @(posedge clk); #1;
        end
        mem_rdy[d] = 0; mem_rv[d] = 0;
        for (int w = 1; w <= lat; w++) begin
            rv = (w == lat);
            mem_rv[d] = rv; mem_rd[d] = rd;
            #1;
            chk("req_valid_wait", mem_v[d], 0);
            chk("ifu_ready_wait", ifu_rdy[d], 0);
            chk("lsu_ready_wait", lsu_rdy[d], 0);
            chk("ifu_resp", ifu_rv[d], rv && !pick_lsu);
            chk("lsu_resp", lsu_rv[d], rv && pick_lsu);
            if (rv) chk("resp_data", pick_lsu ? lsu_rd[d] : ifu_rd[d], rd);
            @(posedge clk); #1;
        end
        mem_rv[d] = 0;
    endtask

    task automatic drain(input int d);
        for (int k = 0; k < 4 && (p_i[d] || p_l[d]); k++) txn(d, 0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ifu_v[d] = 0; lsu_v[d] = 0; lsu_w[d] = 0; mem_rdy[d] = 0; mem_rv[d] = 0;
            ifu_a[d] = 0; lsu_a[d] = 0; lsu_wd[d] = 0; mem_rd[d] = 0; lsu_m[d] = 0;
            p_i[d] = 0; p_l[d] = 0; m_loser[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk_idle_outputs(d);
        rst = 0;
        @(posedge clk); #1;
        txn(0, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 2, 32'h0010_0073);
        txn(0, 1, 32'h8000_0004, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'h0);
        drain(0);
        txn(0, 1, 32'h8000_0008, 0, 0, 0, 0, 0, 5, 1, 32'hCAFE_F00D);
        txn(0, 0, 0, 1, 32'h8000_2000, 0, 0, 4'h3, 0, 0, 32'h1111_2222);
        txn(0, 1, 32'h8000_000C, 0, 0, 0, 0, 0, 0, 0, 32'h3333_4444);
        txn(1, 1, 32'h8000_0010, 1, 32'h8000_3000, 1, 32'h5555_6666, 4'h1, 0, 1, 32'h7);
        txn(1, 1, 32'h8000_0014, 0, 0, 0, 0, 0, 0, 1, 32'h8);
        txn(1, 0, 0, 1, 32'h8000_3004, 0, 0, 4'hC, 0, 1, 32'h9);
        drain(1);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 40; k++)
                txn(d, $urandom % 2, $urandom, $urandom % 2, $urandom, $urandom % 2, $urandom,
                    4'($urandom), $urandom % 4, $urandom % 4, $urandom);
            drain(d);
        end
        mem_rv[0] = 1; mem_rd[0] = 32'hBAD0_BAD0;
        #1;
        chk("stale_ifu", ifu_rv[0], 0); chk("stale_lsu", lsu_rv[0], 0);
        @(posedge clk); #1;
        mem_rv[0] = 0;
        ifu_v[0] = 1; ifu_a[0] = 32'h8000_0040;
        @(posedge clk); #1;
        ifu_v[0] = 0; mem_rdy[0] = 1;
        @(posedge clk); #1;
        mem_rdy[0] = 0; rst = 1; ifu_v[0] = 1;
        @(posedge clk); #1;
        chk_idle_outputs(0);
        rst = 0; ifu_v[0] = 0; m_loser[0] = 0; m_loser[1] = 0;
        mem_rv[0] = 1; mem_rd[0] = 32'h1234_5678;
        #1;
        chk("rst_resp_ifu", ifu_rv[0], 0); chk("rst_resp_lsu", lsu_rv[0], 0);
        @(posedge clk); #1;
        mem_rv[0] = 0;
        txn(0, 1, 32'h8000_0044, 0, 0, 0, 0, 0, 1, 2, 32'hA5A5_5A5A);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
